// File: rtl/pfd_pkg.sv
`default_nettype none
// ======================================================================
// pfd_pkg: state encoding and helpers shared by the digital PFD
// Revision: 1.0
// ======================================================================
package pfd_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DN   = 2'd2;
  localparam logic [1:0] ST_BOTH = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_UP   = ST_UP,
    S_DN   = ST_DN,
    S_BOTH = ST_BOTH
  } pfd_state_e;

  // Largest positive value of a signed error of width w.
  function automatic int err_sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pfd_sync.sv
`default_nettype none
// ======================================================================
// pfd_sync: multi-flop synchronizer followed by a registered rising-edge pulse
// Revision: 1.0
// ======================================================================
module pfd_sync
  import pfd_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;
  logic              rise_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      last_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~last_q;
    end
  end

  assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/pfd_digital.sv
`default_nettype none
// ======================================================================
// pfd_digital: clocked three-state PFD with anti-backlash overlap, phase error and lock
// Revision: 1.0
// ======================================================================
module pfd_digital
  import pfd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter int ERR_W       = 8,
  parameter int LOCK_WINDOW = 2,
  parameter int LOCK_COUNT  = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             enable,
  input  logic             ref_i,
  input  logic             fb_i,
  output logic             up,
  output logic             down,
  output logic [ERR_W-1:0] phase_err,
  output logic             err_valid,
  output logic             slip,
  output logic             lock
);

  localparam int OW = $clog2(MIN_PULSE + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [ERR_W-1:0]        CNT_MAX  = ERR_W'(err_sat_max(ERR_W));
  localparam logic [OW-1:0]           OVL_END  = OW'(MIN_PULSE);
  localparam logic [GW-1:0]           GOOD_MAX = GW'(LOCK_COUNT);
  localparam logic signed [ERR_W-1:0] WIN      = ERR_W'(LOCK_WINDOW);

  logic ref_e, fb_e;

  pfd_sync #(.STAGES(SYNC_STAGES)) u_ref_sync (
    .clk_i (wb_clk_i), .rst_i (wb_rst_i), .d_i (ref_i), .rise_o (ref_e)
  );

  pfd_sync #(.STAGES(SYNC_STAGES)) u_fb_sync (
    .clk_i (wb_clk_i), .rst_i (wb_rst_i), .d_i (fb_i), .rise_o (fb_e)
  );

  pfd_state_e       state_q, state_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [OW-1:0]    ovl_q, ovl_d;
  logic             pend_ref_q, pend_ref_d, pend_fb_q, pend_fb_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             err_valid_q, err_valid_d, slip_q, slip_d;
  logic             up_q, up_d, down_q, down_d;
  logic [GW-1:0]    good_q, good_d;
  logic             lock_q, lock_d;

  logic                    leave_both, eff_ref, eff_fb, in_win;
  logic [ERR_W-1:0]        cnt_inc;
  logic signed [ERR_W-1:0] err_s;

  assign leave_both = (state_q == S_BOTH) && (ovl_q == OVL_END);
  // Pending flags are only ever set inside BOTH, so outside BOTH they are zero.
  assign eff_ref    = ref_e | pend_ref_q;
  assign eff_fb     = fb_e | pend_fb_q;
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ERR_W'(1);
  assign err_s      = err_q;
  assign in_win     = (err_s <= WIN) && (err_s >= -WIN);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovl_d       = ovl_q;
    pend_ref_d  = pend_ref_q;
    pend_fb_d   = pend_fb_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    slip_d      = 1'b0;

    case (state_q)
      S_UP: begin
        if (fb_e) begin
          state_d     = S_BOTH;
          err_d       = cnt_q;
          err_valid_d = 1'b1;
          ovl_d       = OW'(1);
          pend_ref_d  = ref_e;
        end else begin
          cnt_d  = cnt_inc;
          slip_d = ref_e;
        end
      end
      S_DN: begin
        if (ref_e) begin
          state_d     = S_BOTH;
          err_d       = ERR_W'(0) - cnt_q;
          err_valid_d = 1'b1;
          ovl_d       = OW'(1);
          pend_fb_d   = fb_e;
        end else begin
          cnt_d  = cnt_inc;
          slip_d = fb_e;
        end
      end
      S_BOTH: begin
        if (!leave_both) begin
          ovl_d      = ovl_q + OW'(1);
          pend_ref_d = pend_ref_q | ref_e;
          pend_fb_d  = pend_fb_q | fb_e;
        end
      end
      default: ;
    endcase

    // Leaving BOTH is decoded exactly like IDLE so pending edges start the next pulse at once.
    if (state_q == S_IDLE || leave_both) begin
      state_d    = S_IDLE;
      pend_ref_d = 1'b0;
      pend_fb_d  = 1'b0;
      if (eff_ref && eff_fb) begin
        state_d     = S_BOTH;
        err_d       = '0;
        err_valid_d = 1'b1;
        ovl_d       = OW'(1);
      end else if (eff_ref) begin
        state_d = S_UP;
        cnt_d   = ERR_W'(1);
      end else if (eff_fb) begin
        state_d = S_DN;
        cnt_d   = ERR_W'(1);
      end
    end

    if (!enable) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      ovl_d       = '0;
      pend_ref_d  = 1'b0;
      pend_fb_d   = 1'b0;
      err_valid_d = 1'b0;
      slip_d      = 1'b0;
    end

    up_d   = (state_d == S_UP) || (state_d == S_BOTH);
    down_d = (state_d == S_DN) || (state_d == S_BOTH);
  end

  always_comb begin
    good_d = good_q;
    lock_d = lock_q;
    if (slip_q) begin
      good_d = '0;
      lock_d = 1'b0;
    end else if (err_valid_q) begin
      if (in_win) begin
        if (good_q != GOOD_MAX) good_d = good_q + GW'(1);
        if (good_d == GOOD_MAX) lock_d = 1'b1;
      end else begin
        good_d = '0;
        lock_d = 1'b0;
      end
    end
    if (!enable) begin
      good_d = '0;
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ovl_q       <= '0;
      pend_ref_q  <= 1'b0;
      pend_fb_q   <= 1'b0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      slip_q      <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      good_q      <= '0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ovl_q       <= ovl_d;
      pend_ref_q  <= pend_ref_d;
      pend_fb_q   <= pend_fb_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      slip_q      <= slip_d;
      up_q        <= up_d;
      down_q      <= down_d;
      good_q      <= good_d;
      lock_q      <= lock_d;
    end
  end

  assign up        = up_q;
  assign down      = down_q;
  assign phase_err = err_q;
  assign err_valid = err_valid_q;
  assign slip      = slip_q;
  assign lock      = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_pfd_digital.sv
`default_nettype none
// ======================================================================
// tb_pfd_digital: self-checking bench for the digital PFD
// Revision: 1.0
// ======================================================================
module tb_pfd_digital;

  localparam int SYNC = 2;
  localparam int MP   = 2;
  localparam int EW   = 8;
  localparam int WIN  = 2;
  localparam int LCNT = 16;
  localparam int EMAX = (1 << (EW - 1)) - 1;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic          enable;
  logic          ref_in;
  logic          fb_in;
  logic          up, down, err_valid, slip, lock;
  logic [EW-1:0] phase_err;

  int nchk = 0;
  int nerr = 0;
  int model_good = 0;

  typedef struct {
    int lead;
    int e_err;
    int e_up;
    int e_dn;
  } vec_t;

  vec_t vecs [6];

  pfd_digital #(
    .SYNC_STAGES (SYNC), .MIN_PULSE (MP), .ERR_W (EW),
    .LOCK_WINDOW (WIN), .LOCK_COUNT (LCNT)
  ) dut (
    .wb_clk_i  (wb_clk),
    .wb_rst_i  (wb_rst),
    .enable    (enable),
    .ref_i     (ref_in),
    .fb_i      (fb_in),
    .up        (up),
    .down      (down),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .slip      (slip),
    .lock      (lock)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic cyc();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    ref_in = 1'b0;
    fb_in  = 1'b0;
    repeat (2) cyc();
    wb_rst = 1'b0;
    cyc();
    model_good = 0;
  endtask

  // Lock reference: a run of in-window comparisons, broken by any outlier.
  task automatic model_lock(input int e_err, output int exp_lock);
    if (e_err >= -WIN && e_err <= WIN)
      model_good = (model_good < LCNT) ? model_good + 1 : LCNT;
    else
      model_good = 0;
    exp_lock = (model_good == LCNT) ? 1 : 0;
  endtask

  // One ref/fb comparison: the later input rises |lead| clocks after the earlier one.
  task automatic compare(input int lead, input int e_err, input int e_up, input int e_dn);
    int a, b, hi, n, nup, ndn, nval, got_err, first_up, got_lock, exp_lock;
    bit lp;
    a = (lead < 0) ? -lead : 0;
    b = (lead > 0) ? lead : 0;
    hi = ((a > b) ? a : b) + 4;
    n = hi + 16;
    nup = 0; ndn = 0; nval = 0; got_err = -999; first_up = -1; got_lock = -1; lp = 1'b0;
    for (int c = 0; c < n; c++) begin
      ref_in = (c >= a && c < hi);
      fb_in  = (c >= b && c < hi);
      cyc();
      if (up) begin
        nup++;
        if (first_up < 0) first_up = c;
      end
      if (down) ndn++;
      if (lp) begin
        got_lock = int'(lock);
        lp = 1'b0;
      end
      if (err_valid) begin
        nval++;
        got_err = int'($signed(phase_err));
        lp = 1'b1;
      end
    end
    ref_in = 1'b0;
    fb_in  = 1'b0;
    model_lock(e_err, exp_lock);
    chk($sformatf("err_valid_count lead=%0d", lead), nval, 1);
    chk($sformatf("phase_err lead=%0d", lead), got_err, e_err);
    chk($sformatf("up_cycles lead=%0d", lead), nup, e_up);
    chk($sformatf("down_cycles lead=%0d", lead), ndn, e_dn);
    chk($sformatf("lock lead=%0d", lead), got_lock, exp_lock);
    if (lead > 0) chk($sformatf("up_latency lead=%0d", lead), first_up, SYNC + 1);
  endtask

  task automatic run_lead(input int lead);
    int e;
    e = (lead > EMAX) ? EMAX : ((lead < -EMAX) ? -EMAX : lead);
    compare(lead, e, ((lead > 0) ? lead : 0) + MP, ((lead < 0) ? -lead : 0) + MP);
  endtask

  initial begin
    int nval, nfall, ndn, nslip, slip_lock, nact, nact2, got;
    int errs [4];
    bit prev_up, lp;

    vecs[0] = '{5, 5, 5 + MP, MP};
    vecs[1] = '{-3, -3, MP, 3 + MP};
    vecs[2] = '{0, 0, MP, MP};
    vecs[3] = '{1, 1, 1 + MP, MP};
    vecs[4] = '{-2, -2, MP, 2 + MP};
    vecs[5] = '{9, 9, 9 + MP, MP};

    enable = 1'b1;
    do_reset();
    chk("reset_up", up, 0);
    chk("reset_down", down, 0);
    chk("reset_err_valid", err_valid, 0);
    chk("reset_slip", slip, 0);
    chk("reset_lock", lock, 0);
    chk("reset_phase_err", int'(phase_err), 0);

    for (int i = 0; i < 6; i++)
      compare(vecs[i].lead, vecs[i].e_err, vecs[i].e_up, vecs[i].e_dn);

    // Ref re-arms during the overlap; it must start the next up pulse with no gap.
    nval = 0; nfall = 0; ndn = 0; prev_up = 1'b0;
    for (int i = 0; i < 4; i++) errs[i] = -999;
    for (int c = 0; c < 40; c++) begin
      ref_in = (c < 4) || (c >= 11 && c < 15);
      fb_in  = (c >= 10 && c < 14) || (c >= 17 && c < 21);
      cyc();
      if (prev_up && !up) nfall++;
      prev_up = up;
      if (down) ndn++;
      if (err_valid) begin
        if (nval < 4) errs[nval] = int'($signed(phase_err));
        nval++;
      end
    end
    ref_in = 1'b0; fb_in = 1'b0;
    model_good = 0;
    chk("pending_err_count", nval, 2);
    chk("pending_err0", errs[0], 10);
    chk("pending_err1", errs[1], 17 - (10 + MP));
    chk("pending_up_falls", nfall, 1);
    chk("pending_down_cycles", ndn, 2 * MP);

    do_reset();
    for (int i = 0; i < LCNT; i++) run_lead((i % 5) - 2);
    run_lead(7);
    for (int i = 0; i < LCNT; i++) run_lead((i % 3) - 1);

    // Second ref edge with fb held low: slip, lock loss, saturated error.
    nslip = 0; nfall = 0; nval = 0; got = -999; slip_lock = -1; lp = 1'b0; prev_up = 1'b0;
    for (int c = 0; c < 240; c++) begin
      ref_in = (c < 4) || (c >= 8 && c < 12);
      fb_in  = (c >= 208 && c < 212);
      cyc();
      if (lp) begin
        slip_lock = int'(lock);
        lp = 1'b0;
      end
      if (slip) begin
        nslip++;
        lp = 1'b1;
      end
      if (prev_up && !up) nfall++;
      prev_up = up;
      if (err_valid) begin
        nval++;
        got = int'($signed(phase_err));
      end
    end
    ref_in = 1'b0; fb_in = 1'b0;
    model_good = 0;
    chk("slip_count", nslip, 1);
    chk("slip_lock_cleared", slip_lock, 0);
    chk("slip_up_falls", nfall, 1);
    chk("slip_err_count", nval, 1);
    chk("slip_err_saturated", got, EMAX);

    for (int i = 0; i < 40; i++) begin
      int lead;
      if ($urandom_range(3) != 0) lead = int'($urandom_range(4)) - 2;
      else lead = int'($urandom_range(40)) - 20;
      run_lead(lead);
    end

    // Reset in the middle of an up pulse.
    ref_in = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      cyc();
      if (up) got = 1;
    end
    chk("rst_up_before", got, 1);
    #2 wb_rst = 1'b1;
    #1;
    chk("rst_up_async", up, 0);
    ref_in = 1'b0;
    cyc(); cyc();
    wb_rst = 1'b0;
    cyc();
    model_good = 0;
    chk("rst_after_up", up, 0);
    chk("rst_after_down", down, 0);
    chk("rst_after_err", int'(phase_err), 0);

    // Disabled: no activity; an edge taken while disabled stays unreported.
    enable = 1'b0;
    nact = 0;
    for (int c = 0; c < 48; c++) begin
      ref_in = (c % 8) < 4;
      fb_in  = ((c + 3) % 8) < 4;
      cyc();
      if (up || down || err_valid || slip || lock) nact++;
    end
    ref_in = 1'b1; fb_in = 1'b0;
    repeat (6) begin
      cyc();
      if (up || down || err_valid || slip || lock) nact++;
    end
    enable = 1'b1;
    nact2 = 0;
    repeat (12) begin
      cyc();
      if (up || down || err_valid || slip) nact2++;
    end
    chk("disabled_quiet", nact, 0);
    chk("reenable_no_stale_edge", nact2, 0);
    ref_in = 1'b0;
    repeat (8) cyc();
    model_good = 0;
    run_lead(4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
